// File: rtl/iiitb_rv32i_mem_arbiter_if.sv
// rtl/iiitb_rv32i_mem_arbiter_if.sv - requester, memory and status bus of the IF/D memory arbiter
interface iiitb_rv32i_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // data load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // unified single-port memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // status
  logic              busy;
  logic              arb_err;

  // arbiter side
  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output busy, arb_err
  );

  // core + memory side
  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  busy, arb_err
  );
endinterface

// File: rtl/iiitb_rv32i_mem_arbiter.sv
// rtl/iiitb_rv32i_mem_arbiter.sv - D-priority IF/D arbiter for a single-port unified memory
module iiitb_rv32i_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                   clk,
  input logic                   RN,
  iiitb_rv32i_mem_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        owner_if_q, owner_if_d;   // 1: IF owns the outstanding access, 0: D
  logic        txn_we_q, txn_we_d;       // outstanding access is a D write
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        arb_err_q, arb_err_d;

  logic        resp;
  logic        issue;
  logic        gnt_if;
  logic        gnt_d;

  logic              if_gnt_c, if_rvalid_c, d_gnt_c, d_rvalid_c;
  logic [DATA_W-1:0] if_rdata_c, d_rdata_c, mem_wdata_c;
  logic              mem_en_c, mem_we_c, busy_c, arb_err_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [STRB_W-1:0] mem_wstrb_c;

  // Arbitration and next-state: issue while idle or in the response cycle, D wins unless IF is starved
  always_comb begin
    state_d      = state_q;
    owner_if_d   = owner_if_q;
    txn_we_d     = txn_we_q;
    starve_cnt_d = starve_cnt_q;
    arb_err_d    = arb_err_q;

    resp   = (state_q == BUSY) && bus.mem_rvalid;
    issue  = (state_q == IDLE) || resp;
    gnt_if = issue && bus.if_req && (!bus.d_req || (starve_cnt_q >= STARVE_LIM));
    gnt_d  = issue && bus.d_req && !gnt_if;

    if (gnt_if || gnt_d) begin
      state_d    = BUSY;
      owner_if_d = gnt_if;
      txn_we_d   = gnt_d && bus.d_we;
    end else if (resp) begin
      state_d = IDLE;
    end

    // gnt_d with if_req high means IF lost a contested arbitration
    if (gnt_if) begin
      starve_cnt_d = 4'd0;
    end else if (gnt_d && bus.if_req && (starve_cnt_q != 4'hF)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // a response with nothing outstanding is dropped and remembered
    if ((state_q == IDLE) && bus.mem_rvalid) begin
      arb_err_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (RN) begin
      state_q      <= IDLE;
      owner_if_q   <= 1'b0;
      txn_we_q     <= 1'b0;
      starve_cnt_q <= 4'd0;
      arb_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_if_q   <= owner_if_d;
      txn_we_q     <= txn_we_d;
      starve_cnt_q <= starve_cnt_d;
      arb_err_q    <= arb_err_d;
    end
  end

  // Output muxing: memory driven from the winner, response routed to the owner, all zero in reset
  always_comb begin
    if_gnt_c    = 1'b0;
    d_gnt_c     = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_wstrb_c = '0;
    if_rvalid_c = 1'b0;
    if_rdata_c  = '0;
    d_rvalid_c  = 1'b0;
    d_rdata_c   = '0;
    busy_c      = 1'b0;
    arb_err_c   = 1'b0;

    if (!RN) begin
      if_gnt_c = gnt_if;
      d_gnt_c  = gnt_d;
      mem_en_c = gnt_if || gnt_d;
      if (gnt_d) begin
        mem_we_c    = bus.d_we;
        mem_addr_c  = bus.d_addr;
        mem_wdata_c = bus.d_wdata;
        mem_wstrb_c = bus.d_wstrb;
      end else if (gnt_if) begin
        mem_addr_c  = bus.if_addr;
      end

      if_rvalid_c = resp && owner_if_q;
      d_rvalid_c  = resp && !owner_if_q;
      if (if_rvalid_c) begin
        if_rdata_c = bus.mem_rdata;
      end
      // a write acknowledge never carries data back
      if (d_rvalid_c && !txn_we_q) begin
        d_rdata_c = bus.mem_rdata;
      end

      busy_c    = (state_q == BUSY);
      arb_err_c = arb_err_q;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.if_rvalid = if_rvalid_c;
  assign bus.if_rdata  = if_rdata_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.d_rvalid  = d_rvalid_c;
  assign bus.d_rdata   = d_rdata_c;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_wstrb = mem_wstrb_c;
  assign bus.busy      = busy_c;
  assign bus.arb_err   = arb_err_c;
endmodule

// File: tb/tb_iiitb_rv32i_mem_arbiter.sv
// tb/tb_iiitb_rv32i_mem_arbiter.sv - self-checking bench for the IF/D memory arbiter
module tb_iiitb_rv32i_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic RN;
  always #5 clk = ~clk;

  iiitb_rv32i_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iiitb_rv32i_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .RN  (RN),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // reference model: what is outstanding, who owns it, how often IF has lost, sticky error
  bit m_busy, m_own_if, m_we, m_err;
  int m_starve;

  // observations of the last stepped cycle
  logic              o_if_gnt, o_d_gnt, o_mem_en, o_mem_we, o_if_rvalid, o_d_rvalid, o_busy, o_arb_err;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata, o_if_rdata, o_d_rdata;
  logic [STRB_W-1:0] o_mem_wstrb;
  bit                last_gif, last_gd;

  // one clock: sample mid-cycle, compare against the model, advance the model
  task automatic step();
    bit                resp, w_if, w_d, g_if, g_d;
    bit                e_if_rv, e_d_rv, e_we, e_busy, e_err;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_if_rdata, e_d_rdata;
    logic [STRB_W-1:0] e_strb;
    @(negedge clk);
    o_if_gnt = bus.if_gnt;     o_d_gnt = bus.d_gnt;       o_mem_en = bus.mem_en;
    o_mem_we = bus.mem_we;     o_mem_addr = bus.mem_addr; o_mem_wdata = bus.mem_wdata;
    o_mem_wstrb = bus.mem_wstrb;
    o_if_rvalid = bus.if_rvalid; o_if_rdata = bus.if_rdata;
    o_d_rvalid = bus.d_rvalid;   o_d_rdata = bus.d_rdata;
    o_busy = bus.busy;           o_arb_err = bus.arb_err;

    g_if = 0; g_d = 0; resp = 0;
    e_if_rv = 0; e_d_rv = 0; e_we = 0; e_busy = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0; e_strb = '0;
    if (!RN) begin
      resp = m_busy && bus.mem_rvalid;
      w_if = (!m_busy || resp) && bus.if_req;
      w_d  = (!m_busy || resp) && bus.d_req;
      g_if = w_if && (!w_d || m_starve >= STARVE_MAX);
      g_d  = w_d && !g_if;
      if (g_d) begin
        e_we = bus.d_we; e_addr = bus.d_addr; e_wdata = bus.d_wdata; e_strb = bus.d_wstrb;
      end else if (g_if) begin
        e_addr = bus.if_addr;
      end
      e_if_rv = resp && m_own_if;
      e_d_rv  = resp && !m_own_if;
      if (e_if_rv) e_if_rdata = bus.mem_rdata;
      if (e_d_rv && !m_we) e_d_rdata = bus.mem_rdata;
      e_busy = m_busy;
      e_err  = m_err;
    end

    check("if_gnt", o_if_gnt, g_if);
    check("d_gnt", o_d_gnt, g_d);
    check("mem_en", o_mem_en, g_if || g_d);
    check("mem_we", o_mem_we, e_we);
    check("mem_addr", o_mem_addr, e_addr);
    check("mem_wdata", o_mem_wdata, e_wdata);
    check("mem_wstrb", o_mem_wstrb, e_strb);
    check("if_rvalid", o_if_rvalid, e_if_rv);
    check("if_rdata", o_if_rdata, e_if_rdata);
    check("d_rvalid", o_d_rvalid, e_d_rv);
    check("d_rdata", o_d_rdata, e_d_rdata);
    check("busy", o_busy, e_busy);
    check("arb_err", o_arb_err, e_err);

    if (RN) begin
      m_busy = 0; m_own_if = 0; m_we = 0; m_starve = 0; m_err = 0;
    end else begin
      if (!m_busy && bus.mem_rvalid) m_err = 1;
      if (g_d && bus.if_req) m_starve = (m_starve >= 15) ? 15 : m_starve + 1;
      if (g_if) m_starve = 0;
      if (g_if || g_d) begin
        m_busy = 1; m_own_if = g_if; m_we = g_d && bus.d_we;
      end else if (resp) begin
        m_busy = 0;
      end
    end
    last_gif = g_if;
    last_gd  = g_d;
    @(posedge clk);
    #1;
  endtask

  // random traffic: requesters hold until granted, memory answers after 1..3 cycles
  logic [DATA_W-1:0] memarr [16];
  bit                mem_active, mem_wr;
  int                mem_cnt;
  logic [3:0]        mem_idx;

  task automatic rand_drive();
    if (bus.mem_rvalid) mem_active = 0;
    if (last_gif) begin
      mem_active = 1; mem_cnt = $urandom_range(1, 3); mem_wr = 0; mem_idx = bus.if_addr[5:2];
      bus.if_req = 0;
    end
    if (last_gd) begin
      mem_active = 1; mem_cnt = $urandom_range(1, 3); mem_wr = bus.d_we; mem_idx = bus.d_addr[5:2];
      if (bus.d_we)
        for (int b = 0; b < STRB_W; b++)
          if (bus.d_wstrb[b]) memarr[mem_idx][8*b +: 8] = bus.d_wdata[8*b +: 8];
      bus.d_req = 0;
    end
    if (!bus.if_req) begin
      bus.if_addr = ADDR_W'($urandom_range(0, 15)) << 2;
      bus.if_req  = ($urandom_range(0, 2) != 0);
    end
    if (!bus.d_req) begin
      bus.d_we    = $urandom_range(0, 1) == 1;
      bus.d_addr  = ADDR_W'($urandom_range(0, 15)) << 2;
      bus.d_wdata = $urandom;
      bus.d_wstrb = STRB_W'($urandom);
      bus.d_req   = ($urandom_range(0, 2) != 0);
    end
    bus.mem_rvalid = 0;
    bus.mem_rdata  = $urandom;
    if (mem_active) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.mem_rvalid = 1;
        bus.mem_rdata  = mem_wr ? ($urandom | 32'h1) : memarr[mem_idx];
      end
    end
  endtask

  logic [9:0] gseq;

  initial begin
    RN = 1;
    bus.if_req = 1; bus.if_addr = 32'h10;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.mem_rvalid = 0; bus.mem_rdata = '0;
    m_busy = 0; m_own_if = 0; m_we = 0; m_starve = 0; m_err = 0;
    for (int i = 0; i < 16; i++) memarr[i] = $urandom;
    mem_active = 0; mem_cnt = 0; mem_wr = 0; mem_idx = '0;

    // reset with both requesting: everything quiet, then D wins first
    step(); check("rst_no_gnt", {o_if_gnt, o_d_gnt, o_mem_en}, 3'b000);
    step(); check("rst_no_gnt2", {o_if_gnt, o_d_gnt, o_mem_en}, 3'b000);
    RN = 0;
    step(); check("first_d_gnt", {o_if_gnt, o_d_gnt, o_mem_en}, 3'b011);
    bus.if_req = 0; bus.d_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1;
    step(); bus.mem_rvalid = 0;

    // IF-only read, response two cycles after the grant
    bus.if_req = 1; bus.if_addr = 32'h10;
    step(); check("ifrd_gnt", o_if_gnt, 1); check("ifrd_addr", o_mem_addr, 32'h10);
    bus.if_req = 0;
    step(); check("ifrd_busy1", o_busy, 1);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h00500093;
    step(); check("ifrd_busy2", o_busy, 1); check("ifrd_rvalid", o_if_rvalid, 1);
    check("ifrd_rdata", o_if_rdata, 32'h00500093); check("ifrd_no_d", o_d_rvalid, 0);
    bus.mem_rvalid = 0;

    // D write, acknowledge carries no data
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'hF;
    step(); check("dwr_we", o_mem_we, 1); check("dwr_strb", o_mem_wstrb, 4'hF);
    check("dwr_wdata", o_mem_wdata, 32'hDEADBEEF);
    bus.d_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234;
    step(); check("dwr_ack", o_d_rvalid, 1); check("dwr_rdata0", o_d_rdata, 0);
    bus.mem_rvalid = 0;

    // starvation with latency 1: D,D,D,D,IF repeating
    bus.if_req = 1; bus.d_req = 1; bus.d_we = 0; bus.if_addr = 32'h20; bus.d_addr = 32'h80;
    gseq = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      gseq[i] = last_gif;
      if (last_gif) check("starve_clr", dut.starve_cnt_q, 0);
      bus.mem_rvalid = 1; bus.mem_rdata = 32'hA000_0000 | 32'(i);
    end
    check("starve_seq", gseq, 10'b10_0001_0000);

    // back-to-back: D issued in the IF response cycle
    bus.if_req = 0;
    step(); check("b2b_if_rv", o_if_rvalid, 1); check("b2b_d_gnt", {o_d_gnt, o_mem_en}, 2'b11);
    check("b2b_busy", o_busy, 1);
    bus.d_req = 0; bus.mem_rdata = 32'hCAFE0001;
    step(); check("b2b_nobubble", o_busy, 1); check("b2b_d_rdata", o_d_rdata, 32'hCAFE0001);
    bus.mem_rvalid = 0;
    step(); check("b2b_idle", o_busy, 0);

    // stray response while idle
    bus.mem_rvalid = 1;
    step(); check("perr_no_rv", {o_if_rvalid, o_d_rvalid}, 2'b00);
    bus.mem_rvalid = 0;
    step(); check("perr_flag", o_arb_err, 1);

    // reset while busy, then a late response
    bus.if_req = 1;
    step(); check("mid_gnt", o_if_gnt, 1);
    bus.if_req = 0; RN = 1;
    step();
    RN = 0;
    step(); check("mid_busy0", o_busy, 0); check("mid_err0", o_arb_err, 0);
    bus.mem_rvalid = 1;
    step(); check("late_no_rv", {o_if_rvalid, o_d_rvalid}, 2'b00);
    bus.mem_rvalid = 0;
    step(); check("late_err", o_arb_err, 1);

    // randomized traffic against the model
    RN = 1; step(); RN = 0;
    last_gif = 0; last_gd = 0; bus.if_req = 0; bus.d_req = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      step();
    end
    check("rand_no_err", o_arb_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
